// File: rtl/rr_packet_arbiter11.sv
// rtl/rr_packet_arbiter11.sv - round-robin packet arbiter, four flit inputs onto one registered output
// An input keeps the output from its first transfer until its tail flit transfers.
module rr_packet_arbiter11 #(
   parameter int WIDTH = 11,
   parameter int N     = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [N*WIDTH-1:0]   in_data,
   input  logic [N-1:0]         in_valid,
   output logic [N-1:0]         in_ready,
   output logic [WIDTH-1:0]     out_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [N-1:0]         grant,
   output logic                 busy
);

   localparam int PW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [PW-1:0]    ptr;
   logic [PW-1:0]    ptr_next;
   logic [N-1:0]     grant_next;
   logic [WIDTH-1:0] sel_flit;
   logic             xfer;
   logic             found;
   int               cand;
   int               win;

   // The output stage frees up when empty or when its flit leaves this edge.
   assign in_ready = grant & {N{~out_valid | out_ready}};
   assign xfer     = |(in_valid & in_ready);
   assign busy     = (state == LOCKED);

   always_comb begin
      sel_flit = '0;
      for (int i = 0; i < N; i++) begin
         if (grant[i]) begin
            sel_flit = in_data[i*WIDTH +: WIDTH];
         end
      end
   end

   always_comb begin
      state_next = state;
      grant_next = grant;
      ptr_next   = ptr;
      found      = 1'b0;
      cand       = 0;
      win        = 0;
      case (state)
         IDLE: begin
            for (int k = 0; k < N; k++) begin
               cand = int'(ptr) + k;
               if (cand >= N) begin
                  cand = cand - N;
               end
               if (!found && in_valid[PW'(cand)]) begin
                  found = 1'b1;
                  win   = cand;
               end
            end
            if (found) begin
               state_next = LOCKED;
               grant_next = N'(1) << win;
               ptr_next   = (win == N - 1) ? '0 : PW'(win + 1);
            end
         end
         LOCKED: begin
            // Types 10 and 11 both end a packet.
            if (xfer && sel_flit[WIDTH-1]) begin
               state_next = IDLE;
               grant_next = '0;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         ptr   <= '0;
         grant <= '0;
      end else begin
         state <= state_next;
         ptr   <= ptr_next;
         grant <= grant_next;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_data  <= '0;
         out_valid <= 1'b0;
      end else if (xfer) begin
         out_data  <= sel_flit;
         out_valid <= 1'b1;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_rr_packet_arbiter11.sv
// tb/tb_rr_packet_arbiter11.sv - directed bench for rr_packet_arbiter11
module tb_rr_packet_arbiter11;

   localparam int WIDTH = 11;
   localparam int N     = 4;

   logic               clk = 1'b0;
   logic               reset;
   logic [N*WIDTH-1:0] in_data;
   logic [N-1:0]       in_valid;
   logic [N-1:0]       in_ready;
   logic [WIDTH-1:0]   out_data;
   logic               out_valid;
   logic               out_ready;
   logic [N-1:0]       grant;
   logic               busy;

   int total = 0;
   int bad   = 0;

   logic [WIDTH-1:0] bp [4];

   rr_packet_arbiter11 #(.WIDTH(WIDTH), .N(N)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .grant     (grant),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic put(input int i, input logic [WIDTH-1:0] f);
      in_data[i*WIDTH +: WIDTH] = f;
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_grant"}, 32'(grant), 0);
      check({tag, "_busy"}, 32'(busy), 0);
      check({tag, "_ovalid"}, 32'(out_valid), 0);
      check({tag, "_odata"}, 32'(out_data), 0);
      check({tag, "_iready"}, 32'(in_ready), 0);
   endtask

   initial begin
      in_data   = '0;
      reset     = 1'b1;
      in_valid  = 4'hF;
      out_ready = 1'b1;
      for (int i = 0; i < N; i++) put(i, {2'b11, 9'(256 + i)});

      // reset held two cycles with every input requesting
      tick; #1; check_reset_state("rst1");
      tick; #1; check_reset_state("rst2");
      reset = 1'b0;
      #1; check("idle_after_rst", 32'(grant), 0);

      // single flits everywhere: grants rotate 0,1,2,3,0 with an idle cycle between
      for (int k = 0; k < 9; k++) begin
         tick; #1;
         if (k % 2 == 0) begin
            check("rr_grant", 32'(grant), 32'(1) << ((k / 2) % 4));
            check("rr_iready", 32'(in_ready), 32'(1) << ((k / 2) % 4));
            check("rr_busy", 32'(busy), 1);
            check("rr_ovalid_lo", 32'(out_valid), 0);
         end else begin
            check("rr_gap_grant", 32'(grant), 0);
            check("rr_ovalid_hi", 32'(out_valid), 1);
            check("rr_odata", 32'(out_data), 32'({2'b11, 9'(256 + (k - 1) / 2)}));
         end
      end
      tick; in_valid = '0; #1;
      check("rr_last_odata", 32'(out_data), 32'({2'b11, 9'd256}));
      check("rr_last_grant", 32'(grant), 0);
      tick; #1;
      check("rr_drain", 32'(out_valid), 0);

      // three-flit packet on input 2 (ptr now 1)
      in_valid = 4'b0100; put(2, 11'b01_000000001); #1;
      check("pk_idle", 32'(grant), 0);
      tick; #1;
      check("pk_grant", 32'(grant), 32'b0100);
      check("pk_iready", 32'(in_ready), 32'b0100);
      check("pk_ovalid0", 32'(out_valid), 0);
      tick; put(2, 11'b00_000000010); #1;
      check("pk_head_v", 32'(out_valid), 1);
      check("pk_head", 32'(out_data), 32'(11'b01_000000001));
      tick; put(2, 11'b10_000000011); #1;
      check("pk_body", 32'(out_data), 32'(11'b00_000000010));
      tick; in_valid = '0; #1;
      check("pk_tail", 32'(out_data), 32'(11'b10_000000011));
      check("pk_tail_v", 32'(out_valid), 1);
      check("pk_release", 32'(grant), 0);
      tick; #1;
      check("pk_drain", 32'(out_valid), 0);

      // input 1 requests while input 0 is mid-packet (ptr now 3)
      in_valid = 4'b0001; put(0, 11'b01_000001010); #1;
      check("ni_idle", 32'(grant), 0);
      tick; in_valid = 4'b0011; put(1, 11'b11_000001011); #1;
      check("ni_grant0", 32'(grant), 32'b0001);
      check("ni_iready_head", 32'(in_ready), 32'b0001);
      tick; put(0, 11'b00_000001100); #1;
      check("ni_iready_body", 32'(in_ready), 32'b0001);
      check("ni_head", 32'(out_data), 32'(11'b01_000001010));
      tick; put(0, 11'b10_000001101); #1;
      check("ni_iready_tail", 32'(in_ready), 32'b0001);
      check("ni_body", 32'(out_data), 32'(11'b00_000001100));
      tick; in_valid = 4'b0010; #1;
      check("ni_bubble_grant", 32'(grant), 0);
      check("ni_bubble_iready", 32'(in_ready), 0);
      check("ni_tail", 32'(out_data), 32'(11'b10_000001101));
      tick; #1;
      check("ni_grant1", 32'(grant), 32'b0010);
      check("ni_iready1", 32'(in_ready), 32'b0010);
      tick; in_valid = '0; #1;
      check("ni_single1", 32'(out_data), 32'(11'b11_000001011));
      check("ni_release", 32'(grant), 0);
      tick; #1;

      // back-pressure mid-packet on input 2 (ptr now 2)
      bp[0] = 11'b01_000010000;
      bp[1] = 11'b00_000010001;
      bp[2] = 11'b00_000010010;
      bp[3] = 11'b10_000010011;
      in_valid = 4'b0100; put(2, bp[0]); #1;
      check("bp_idle", 32'(grant), 0);
      tick; #1;
      check("bp_grant", 32'(grant), 32'b0100);
      tick; put(2, bp[1]); #1;
      check("bp_f0", 32'(out_data), 32'(bp[0]));
      tick; put(2, bp[2]); out_ready = 1'b0; #1;
      check("bp_f1", 32'(out_data), 32'(bp[1]));
      check("bp_iready_stall", 32'(in_ready), 0);
      for (int j = 0; j < 4; j++) begin
         tick; #1;
         check("bp_hold_data", 32'(out_data), 32'(bp[1]));
         check("bp_hold_valid", 32'(out_valid), 1);
         check("bp_hold_iready", 32'(in_ready), 0);
      end
      tick; out_ready = 1'b1; #1;
      check("bp_resume_iready", 32'(in_ready), 32'b0100);
      check("bp_resume_data", 32'(out_data), 32'(bp[1]));
      tick; put(2, bp[3]); #1;
      check("bp_f2", 32'(out_data), 32'(bp[2]));
      check("bp_f2_v", 32'(out_valid), 1);
      tick; in_valid = '0; #1;
      check("bp_f3", 32'(out_data), 32'(bp[3]));
      check("bp_release", 32'(grant), 0);
      tick; #1;
      check("bp_drain", 32'(out_valid), 0);

      // reset after the head of a packet on input 3, then a fresh packet from input 3
      in_valid = 4'b1000; put(3, 11'b01_000100000); #1;
      check("rm_idle", 32'(grant), 0);
      tick; #1;
      check("rm_grant", 32'(grant), 32'b1000);
      tick; put(3, 11'b00_000100001); reset = 1'b1; #1;
      check("rm_head", 32'(out_data), 32'(11'b01_000100000));
      check("rm_head_v", 32'(out_valid), 1);
      tick; reset = 1'b0; put(3, 11'b01_000100010); #1;
      check_reset_state("rm_rst");
      tick; #1;
      check("rm_regrant", 32'(grant), 32'b1000);
      tick; put(3, 11'b10_000100011); #1;
      check("rm_head2", 32'(out_data), 32'(11'b01_000100010));
      tick; in_valid = '0; #1;
      check("rm_tail2", 32'(out_data), 32'(11'b10_000100011));
      check("rm_release", 32'(grant), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
